arith_seq_ctrl: RTL and testbench
=================================

Name: arith_seq_ctrl

Overview:
Sequencing controller for the 4-bit multicycle arithmetic datapath (operand registers A/B, add/mul/sub/div units, opcode-steered demux/mux, 8-bit output register). It accepts one operation per start/done handshake and drives the datapath load strobes and opcode. It holds the opcode stable for an operation-dependent number of execute cycles and flags divide-by-zero without touching the datapath.

Parameters:
ADD_CYC, 1, execute cycles for opcode 0 (add); legal range 1..2^CNT_W-1
MUL_CYC, 2, execute cycles for opcode 1 (mul)
SUB_CYC, 1, execute cycles for opcode 2 (sub)
DIV_CYC, 4, execute cycles for opcode 3 (div)
CNT_W, 4, width of execute-cycle counter

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
start  input  1  operation request; sampled only in IDLE
op_in  input  2  requested opcode (0 add, 1 mul, 2 sub, 3 div), sampled with start
b_in  input  4  B operand as presented to the datapath B input; used only for divide-by-zero check
ld_a  output  1  load strobe to operand register A
ld_b  output  1  load strobe to operand register B
ld_out  output  1  load strobe to output register
opcode  output  2  opcode to datapath demuxes/mux
busy  output  1  high while an operation is in flight
done  output  1  one-cycle completion pulse
err_div0  output  1  divide-by-zero flag for the last operation

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE; counter=0; ld_a=ld_b=ld_out=0; opcode=0; busy=0; done=0; err_div0=0. Effect is immediate and asynchronous. No partial completion and no done pulse.
- States: IDLE, LOAD, EXEC, WRITE, DONE. All outputs are registered or Moore-decoded from state. No combinational path from start to any output.
- IDLE: busy=0. On start=1:
  - op_in!=3 or b_in!=0: latch op_in into opcode; clear err_div0; go to LOAD.
  - op_in==3 and b_in==0: latch opcode=3; set err_div0=1; go directly to DONE. ld_a, ld_b and ld_out are never asserted for this operation.
- LOAD (1 cycle): ld_a=ld_b=1, busy=1. Counter loads (selected *_CYC - 1). Next state EXEC.
- EXEC: busy=1, no strobes. Counter decrements each cycle. At counter==0, go to WRITE. Dwell is exactly *_CYC cycles.
- WRITE (1 cycle): ld_out=1, busy=1. Next state DONE.
- DONE (1 cycle): done=1, busy=1. Next state IDLE.
- opcode is held constant from the latch edge until the next accepted start. It stays stable across LOAD, EXEC and WRITE.
- err_div0 is sticky until the next accepted start.
- Latency, measured from the clock edge sampling start to the edge where done is high: normal ops = 3 + *_CYC edges (add 4, mul 5, sub 4, div 7 with defaults); divide-by-zero = 1 edge.
- start while busy, including in DONE, is ignored with no queuing. Back-to-back operation: start held high in the first IDLE cycle after DONE is accepted. Minimum issue interval is 4 + *_CYC cycles.
- op_in and b_in are don't-care outside the IDLE sampling edge.
- At most one strobe class is active per cycle: ld_a/ld_b only in LOAD, ld_out only in WRITE.

Decomposition:
- Shared package arith_pkg:
  - opcode constants OP_ADD=2'd0, OP_MUL=2'd1, OP_SUB=2'd2, OP_DIV=2'd3, matching mux input order
  - state encoding constants S_IDLE, S_LOAD, S_EXEC, S_WRITE, S_DONE (3-bit)
  - default cycle-count constants
- One sub-module, arith_lat_cnt: a CNT_W down-counter with load/enable and a zero flag, and the same clk/rst (async active-low) convention. The FSM and opcode-to-count selection stay in arith_seq_ctrl.

Test Plan:
- Reset then add: rst low 2 cycles, start=1, op_in=0, b_in=3 -> ld_a=ld_b=1 at cycle+1, ld_out at cycle+3, done at cycle+4, opcode=0 throughout, err_div0=0.
- Div timing: start, op_in=3, b_in=2 -> EXEC dwell exactly 4 cycles, ld_out at cycle+6, done at cycle+7, busy high cycles 1..7.
- Divide-by-zero: start, op_in=3, b_in=0 -> done at cycle+1, err_div0=1, no ld_* pulses. A following add with b_in=5 clears err_div0 at its accept edge.
- Busy rejection: mul in progress, pulse start with op_in=2 during EXEC and during DONE -> ignored, opcode stays 1, exactly one done.
- Back-to-back: start held high continuously with op_in=1 -> operations accepted every 6 cycles (MUL_CYC=2), one done per operation, opcode stable.
- Reset mid-op: assert rst=0 during DIV EXEC, asynchronously between clock edges -> all outputs 0 immediately. After release, no done pulse until a new start.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared opcode, state and default-latency definitions for the multicycle
// arithmetic datapath and its sequencing controller.
package arith_pkg;

  typedef logic [1:0] op_t;

  // Order matches the datapath result-mux inputs.
  localparam op_t OP_ADD = 2'd0;
  localparam op_t OP_MUL = 2'd1;
  localparam op_t OP_SUB = 2'd2;
  localparam op_t OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int ADD_CYC_DEF = 1;
  localparam int MUL_CYC_DEF = 2;
  localparam int SUB_CYC_DEF = 1;
  localparam int DIV_CYC_DEF = 4;
  localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/arith_seq_ctrl_if.sv
// Request/strobe bundle between an operation requester and the sequencing
// controller that drives the arithmetic datapath.
interface arith_seq_ctrl_if;
  import arith_pkg::*;

  logic       start;
  op_t        op_in;
  logic [3:0] b_in;
  logic       ld_a;
  logic       ld_b;
  logic       ld_out;
  op_t        opcode;
  logic       busy;
  logic       done;
  logic       err_div0;

  modport master (
    output start, op_in, b_in,
    input  ld_a, ld_b, ld_out, opcode, busy, done, err_div0
  );

  modport slave (
    input  start, op_in, b_in,
    output ld_a, ld_b, ld_out, opcode, busy, done, err_div0
  );

endinterface

// File: rtl/arith_lat_cnt.sv
// Execute-latency down-counter: loads a cycle count, decrements while
// enabled and saturates at zero, with a zero flag for the sequencer.
module arith_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/arith_seq_ctrl.sv
// Sequencing controller: one operation per start/done handshake, driving the
// operand/output load strobes and holding the opcode for the execute dwell.
module arith_seq_ctrl
  import arith_pkg::*;
#(
  parameter int ADD_CYC = ADD_CYC_DEF,
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int SUB_CYC = SUB_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  arith_seq_ctrl_if.slave  bus
);

  state_t state_q;
  state_t state_d;
  op_t    opcode_q;
  logic   err_div0_q;
  logic   accept;
  logic   div_by_zero;
  logic   cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  // Counter is preloaded with dwell-1 so EXEC lasts exactly *_CYC cycles.
  function automatic logic [CNT_W-1:0] exec_preload(input op_t op);
    logic [CNT_W-1:0] v;
    v = CNT_W'(ADD_CYC - 1);
    case (op)
      OP_ADD: v = CNT_W'(ADD_CYC - 1);
      OP_MUL: v = CNT_W'(MUL_CYC - 1);
      OP_SUB: v = CNT_W'(SUB_CYC - 1);
      OP_DIV: v = CNT_W'(DIV_CYC - 1);
    endcase
    return v;
  endfunction

  assign accept       = (state_q == S_IDLE) && bus.start;
  assign div_by_zero  = (bus.op_in == OP_DIV) && (bus.b_in == 4'd0);
  assign cnt_load_val = exec_preload(opcode_q);

  arith_lat_cnt #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == S_LOAD),
    .en       (state_q == S_EXEC),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = div_by_zero ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_EXEC;
      S_EXEC:  if (cnt_zero) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Opcode and the div0 flag change only on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_q   <= OP_ADD;
      err_div0_q <= 1'b0;
    end else if (accept) begin
      opcode_q   <= bus.op_in;
      err_div0_q <= div_by_zero;
    end
  end

  assign bus.ld_a     = (state_q == S_LOAD);
  assign bus.ld_b     = (state_q == S_LOAD);
  assign bus.ld_out   = (state_q == S_WRITE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.opcode   = opcode_q;
  assign bus.err_div0 = err_div0_q;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed bench for arith_seq_ctrl; outputs are packed as
// {ld_a, ld_b, ld_out, busy, done, err_div0, opcode[1:0]} and checked per cycle.
module tb_arith_seq_ctrl;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  arith_seq_ctrl_if bus ();

  arith_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] n_done;
  logic [7:0] obs;
  logic [7:0] exp_q[$];

  assign obs = {bus.ld_a, bus.ld_b, bus.ld_out, bus.busy, bus.done,
                bus.err_div0, bus.opcode};

  task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] b);
    bus.start = 1'b1;
    bus.op_in = op;
    bus.b_in  = b;
  endtask

  // Walks exp_q one edge at a time; first edge is the start-sampling edge.
  task automatic play(input string tag, input bit hold);
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      if (!hold && i == 0) bus.start = 1'b0;
      chk_eq($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
      if (obs[3]) n_done = n_done + 8'd1;
    end
    exp_q.delete();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op_in = 2'd0;
    bus.b_in  = 4'd0;
    n_done    = 8'd0;

    #2 rst = 1'b0;
    step();
    step();
    chk_eq("reset_state", obs, 8'h00);
    rst = 1'b1;
    step();

    issue(OP_ADD, 4'd3);
    exp_q = '{8'hD0, 8'h10, 8'h30, 8'h18, 8'h00};
    play("add", 1'b0);

    issue(OP_DIV, 4'd2);
    exp_q = '{8'hD3, 8'h13, 8'h13, 8'h13, 8'h13, 8'h33, 8'h1B, 8'h03};
    play("div", 1'b0);

    issue(OP_DIV, 4'd0);
    exp_q = '{8'h1F, 8'h07};
    play("div0", 1'b0);

    issue(OP_ADD, 4'd5);
    exp_q = '{8'hD0, 8'h10, 8'h30, 8'h18, 8'h00};
    play("add_after_div0", 1'b0);

    // Mul with stray starts while busy in EXEC and in DONE.
    n_done = 8'd0;
    issue(OP_MUL, 4'd4);
    step(); bus.start = 1'b0;
    chk_eq("rej_load", obs, 8'hD1);
    step();
    chk_eq("rej_exec0", obs, 8'h11);
    issue(OP_SUB, 4'd1);
    step(); bus.start = 1'b0;
    chk_eq("rej_exec1", obs, 8'h11);
    step();
    chk_eq("rej_write", obs, 8'h31);
    step();
    chk_eq("rej_done", obs, 8'h19);
    n_done = n_done + 8'd1;
    issue(OP_SUB, 4'd1);
    step(); bus.start = 1'b0;
    chk_eq("rej_idle0", obs, 8'h01);
    step();
    chk_eq("rej_idle1", obs, 8'h01);
    chk_eq("rej_done_count", n_done, 8'd1);

    // Start held high: a new mul every 6 cycles.
    n_done = 8'd0;
    issue(OP_MUL, 4'd1);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(8'hD1); exp_q.push_back(8'h11); exp_q.push_back(8'h11);
      exp_q.push_back(8'h31); exp_q.push_back(8'h19); exp_q.push_back(8'h01);
    end
    play("b2b", 1'b1);
    bus.start = 1'b0;
    chk_eq("b2b_done_count", n_done, 8'd3);

    // Asynchronous reset in the middle of a divide's execute phase.
    issue(OP_DIV, 4'd2);
    step(); bus.start = 1'b0;
    chk_eq("mid_load", obs, 8'hD3);
    step();
    chk_eq("mid_exec", obs, 8'h13);
    #2 rst = 1'b0;
    #1;
    chk_eq("mid_rst_async", obs, 8'h00);
    step();
    chk_eq("mid_rst_hold", obs, 8'h00);
    rst = 1'b1;
    n_done = 8'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_eq($sformatf("post_rst_idle[%0d]", i), obs, 8'h00);
      if (obs[3]) n_done = n_done + 8'd1;
    end
    chk_eq("post_rst_no_done", n_done, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
